// File: rtl/vga_fb_slave.sv
// Shared single-port framebuffer RAM serving the video fetch port and the CPU port.
// Video has priority, bounded by an anti-starvation counter; fixed two-cycle read latency.
module vga_fb_slave #(
  parameter int unsigned AW         = 14,
  parameter int unsigned STARVE_MAX = 8,
  parameter              INIT_FILE  = ""
) (
  input  logic          clk_i,
  input  logic          rst_i,
  // video port
  input  logic          vbus_cyc,
  input  logic          vbus_stb,
  input  logic [AW+1:0] vbus_adr,
  input  logic          vbus_we,
  input  logic [3:0]    vbus_sel,
  input  logic [31:0]   vbus_dat_m,
  output logic          vbus_ack,
  output logic          vbus_stall,
  output logic [31:0]   vbus_dat_s,
  // CPU port
  input  logic          cbus_cyc,
  input  logic          cbus_stb,
  input  logic [AW+1:0] cbus_adr,
  input  logic          cbus_we,
  input  logic [3:0]    cbus_sel,
  input  logic [31:0]   cbus_dat_m,
  output logic          cbus_ack,
  output logic          cbus_stall,
  output logic [31:0]   cbus_dat_s
);

  typedef enum logic {PORT_V = 1'b0, PORT_C = 1'b1} port_e;

  typedef struct packed {
    logic  valid;
    port_e port;
    logic  we;
  } stage_t;

  logic [31:0]   mem [0:(1<<AW)-1];
  logic [31:0]   ram_q;
  logic [7:0]    starve_cnt;
  logic          v_pres, c_pres, grant_v, grant_c, accept;
  logic [AW-1:0] acc_idx;
  logic          acc_we;
  logic [3:0]    acc_sel;
  logic [31:0]   acc_dat;
  stage_t        s1, s2;
  logic          unused_adr_lsb;

  assign unused_adr_lsb = ^{vbus_adr[1:0], cbus_adr[1:0]};

  always_comb begin
    v_pres  = vbus_cyc & vbus_stb;
    c_pres  = cbus_cyc & cbus_stb;
    grant_c = c_pres & (~v_pres | (starve_cnt == 8'(STARVE_MAX)));
    grant_v = v_pres & ~grant_c;
    accept  = grant_v | grant_c;
    acc_idx = grant_c ? cbus_adr[AW+1:2] : vbus_adr[AW+1:2];
    acc_we  = grant_c ? cbus_we          : vbus_we;
    acc_sel = grant_c ? cbus_sel         : vbus_sel;
    acc_dat = grant_c ? cbus_dat_m       : vbus_dat_m;
  end

  assign vbus_stall = v_pres & ~grant_v;
  assign cbus_stall = c_pres & ~grant_c;

  // Acks are gated by the owner's live cyc so an abandoned cycle never sees a stray ack.
  assign vbus_ack = s2.valid & (s2.port == PORT_V) & vbus_cyc;
  assign cbus_ack = s2.valid & (s2.port == PORT_C) & cbus_cyc;

  // RAM: byte-enabled write, registered read; accesses in a reset cycle never write.
  always_ff @(posedge clk_i) begin
    if (accept && acc_we && !rst_i) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (acc_sel[i]) mem[acc_idx][8*i +: 8] <= acc_dat[8*i +: 8];
      end
    end
    ram_q <= mem[acc_idx];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1         <= '0;
      s2         <= '0;
      starve_cnt <= '0;
      vbus_dat_s <= '0;
      cbus_dat_s <= '0;
    end else begin
      s1.valid <= accept;
      s1.port  <= grant_c ? PORT_C : PORT_V;
      s1.we    <= acc_we;
      s2       <= s1;
      if (s1.valid && !s1.we) begin
        if (s1.port == PORT_V) vbus_dat_s <= ram_q;
        else                   cbus_dat_s <= ram_q;
      end
      if (grant_c || !c_pres)
        starve_cnt <= '0;
      else if (grant_v && (starve_cnt < 8'(STARVE_MAX)))
        starve_cnt <= starve_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_vga_fb_slave.sv
// Directed bench for vga_fb_slave: arbitration/latency model with per-port response scoreboards.
module tb_vga_fb_slave;

  localparam int AW = 14;
  localparam int SM = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          v_cyc, v_stb, v_we, c_cyc, c_stb, c_we;
  logic [AW+1:0] v_adr, c_adr;
  logic [3:0]    v_sel, c_sel;
  logic [31:0]   v_dat, c_dat;
  logic          vbus_ack, vbus_stall, cbus_ack, cbus_stall;
  logic [31:0]   vbus_dat_s, cbus_dat_s;

  vga_fb_slave #(.AW(AW), .STARVE_MAX(SM)) dut (
    .clk_i(clk), .rst_i(rst),
    .vbus_cyc(v_cyc), .vbus_stb(v_stb), .vbus_adr(v_adr), .vbus_we(v_we),
    .vbus_sel(v_sel), .vbus_dat_m(v_dat), .vbus_ack(vbus_ack),
    .vbus_stall(vbus_stall), .vbus_dat_s(vbus_dat_s),
    .cbus_cyc(c_cyc), .cbus_stb(c_stb), .cbus_adr(c_adr), .cbus_we(c_we),
    .cbus_sel(c_sel), .cbus_dat_m(c_dat), .cbus_ack(cbus_ack),
    .cbus_stall(cbus_stall), .cbus_dat_s(cbus_dat_s)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    bit          rd;
    logic [31:0] data;
  } resp_t;

  resp_t       qv[$], qc[$];
  logic [31:0] mm [int];
  int          starve = 0;
  int          k = 0;
  int          vectors = 0;
  int          miscompares = 0;
  bit          last_gv, last_gc;
  logic        s_cstall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s (cycle %0d): got %h expected %h", tag, k, obs, exp);
    end
  endtask

  task automatic vset(input logic cy, input logic [AW+1:0] a, input logic w,
                      input logic [3:0] s, input logic [31:0] d);
    v_cyc = cy; v_stb = cy; v_adr = a; v_we = w; v_sel = s; v_dat = d;
  endtask

  task automatic cset(input logic cy, input logic [AW+1:0] a, input logic w,
                      input logic [3:0] s, input logic [31:0] d);
    c_cyc = cy; c_stb = cy; c_adr = a; c_we = w; c_sel = s; c_dat = d;
  endtask

  task automatic idle();
    vset(0, '0, 0, '0, '0);
    cset(0, '0, 0, '0, '0);
  endtask

  task automatic check_ack(input bit p, input logic ack, input logic cy, input logic [31:0] dat);
    resp_t e;
    bit    exp_ack, rd;
    logic [31:0] exp_dat;
    exp_ack = 0; rd = 0; exp_dat = '0;
    if (p == 0 && qv.size() > 0 && qv[0].due == k) begin
      e = qv.pop_front(); exp_ack = cy; rd = e.rd; exp_dat = e.data;
    end
    if (p == 1 && qc.size() > 0 && qc[0].due == k) begin
      e = qc.pop_front(); exp_ack = cy; rd = e.rd; exp_dat = e.data;
    end
    chk(p ? "cbus_ack" : "vbus_ack", {31'b0, ack}, {31'b0, exp_ack});
    if (exp_ack && rd) chk(p ? "cbus_dat_s" : "vbus_dat_s", dat, exp_dat);
  endtask

  task automatic accept(input bit p, input logic [AW+1:0] a, input logic w,
                        input logic [3:0] s, input logic [31:0] d);
    resp_t e;
    int    key;
    key = int'(a >> 2);
    e.due = k + 2; e.rd = !w; e.data = '0;
    if (w) begin
      if (!mm.exists(key)) mm[key] = '0;
      for (int i = 0; i < 4; i++) if (s[i]) mm[key][8*i +: 8] = d[8*i +: 8];
    end else begin
      e.data = mm[key];
    end
    if (p) qc.push_back(e); else qv.push_back(e);
  endtask

  // One clock cycle: check stalls/acks against the model, account accepts, advance.
  task automatic step();
    bit vp, cp, gv, gc;
    #1;
    vp = v_cyc && v_stb;
    cp = c_cyc && c_stb;
    gc = cp && (!vp || starve == SM);
    gv = vp && !gc;
    chk("vbus_stall", {31'b0, vbus_stall}, {31'b0, vp && !gv});
    chk("cbus_stall", {31'b0, cbus_stall}, {31'b0, cp && !gc});
    s_cstall = cbus_stall;
    check_ack(0, vbus_ack, v_cyc, vbus_dat_s);
    check_ack(1, cbus_ack, c_cyc, cbus_dat_s);
    last_gv = gv; last_gc = gc;
    if (rst) begin
      starve = 0;
      while (qv.size() > 0 && qv[$].due > k) void'(qv.pop_back());
      while (qc.size() > 0 && qc[$].due > k) void'(qc.pop_back());
    end else begin
      if (gv) accept(0, v_adr, v_we, v_sel, v_dat);
      if (gc) accept(1, c_adr, c_we, c_sel, c_dat);
      if (gc || !cp) starve = 0;
      else if (gv && starve < SM) starve++;
    end
    @(posedge clk);
    k++;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  int  stall_len;
  bit  c_done;

  initial begin
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    step();
    chk("rst_vdat", vbus_dat_s, 32'h0);
    chk("rst_cdat", cbus_dat_s, 32'h0);
    rst = 1'b0;

    // full write then read-after-write, then partial byte write
    cset(1, 16'h0010, 1, 4'hF, 32'hDEADBEEF); step();
    cset(1, 16'h0010, 0, 4'hF, 32'h0);        step();
    idle(); repeat (3) step();
    cset(1, 16'h0010, 1, 4'h3, 32'h00001122); step();
    cset(1, 16'h0010, 0, 4'h0, 32'h0);        step();
    idle(); repeat (3) step();
    chk("partial_write", cbus_dat_s, 32'hDEAD1122);

    // preload 0x00..0x4C; sel=0 write must not modify 0x40
    for (int i = 0; i < 20; i++) begin
      cset(1, 16'(i * 4), 1, 4'hF, 32'hA5000000 ^ (i * 32'h01010101));
      step();
    end
    cset(1, 16'h0040, 1, 4'h0, 32'h22222222); step();
    cset(1, 16'h0040, 0, 4'h0, 32'h0);        step();
    idle(); repeat (3) step();

    // video burst, CPU idle
    for (int i = 0; i < 16; i++) begin
      vset(1, 16'(i * 4), 0, 4'hF, 32'h0);
      step();
    end
    idle(); repeat (3) step();

    // starvation: video streams while CPU holds one read
    stall_len = 0;
    c_done = 0;
    for (int i = 0; i < 12; i++) begin
      vset(1, 16'(i * 4), 0, 4'hF, 32'h0);
      if (!c_done) cset(1, 16'h0010, 0, 4'hF, 32'h0);
      else         cset(0, '0, 0, '0, '0);
      step();
      if (s_cstall === 1'b1) stall_len++;
      if (last_gc) c_done = 1;
    end
    chk("starve_len", 32'(stall_len), 32'(SM));
    idle(); repeat (3) step();

    // abort: video abandons two reads, CPU read in between still completes
    vset(1, 16'h0000, 0, 4'hF, 32'h0); step();
    vset(1, 16'h0004, 0, 4'hF, 32'h0); step();
    vset(0, '0, 0, '0, '0);
    cset(1, 16'h0008, 0, 4'hF, 32'h0); step();
    idle(); repeat (4) step();

    // reset with accesses in flight
    cset(1, 16'h0080, 1, 4'hF, 32'hCAFEF00D); step();
    idle(); repeat (3) step();
    vset(1, 16'h0080, 0, 4'hF, 32'h0); step();
    rst = 1'b1;
    vset(0, '0, 0, '0, '0);
    cset(1, 16'h0080, 0, 4'hF, 32'h0); step();
    rst = 1'b0;
    idle(); repeat (4) step();
    chk("post_rst_vdat", vbus_dat_s, 32'h0);
    chk("post_rst_cdat", cbus_dat_s, 32'h0);
    cset(1, 16'h0080, 0, 4'hF, 32'h0); step();
    idle(); repeat (3) step();
    chk("post_rst_read", cbus_dat_s, 32'hCAFEF00D);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
